// File: rtl/mdr_pkg.sv
// -----------------------------------------------------------------------------
// mdr_pkg -- shared definitions for the memory data register (MDR) unit.
//
// Contents:
//   MDR_DATA_W   default data path width
//   mdr_state_e  transaction state: IDLE, RD_WAIT, WR_WAIT
// -----------------------------------------------------------------------------
package mdr_pkg;

    localparam int MDR_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } mdr_state_e;

endpackage : mdr_pkg

// File: rtl/mdr_if.sv
// -----------------------------------------------------------------------------
// mdr_if -- memory-side handshake bundle of the MDR unit.
//
// Signals:
//   mem_req    request, held by the unit until mem_ready
//   mem_we     1 = write, 0 = read
//   mem_wdata  write data (the MDR contents)
//   mem_rdata  read data, valid with mem_ready
//   mem_ready  completion acknowledge from memory
//
// Modports:
//   master  the MDR unit side (drives the request)
//   slave   the memory side (drives the acknowledge and read data)
// -----------------------------------------------------------------------------
interface mdr_if
    import mdr_pkg::*;
#(
    parameter int DATA_W = MDR_DATA_W
);

    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );

endinterface : mdr_if

// File: rtl/mdr_timeout_ctr.sv
// -----------------------------------------------------------------------------
// mdr_timeout_ctr -- watchdog for an outstanding memory transaction.
//
// Counts rising edges while run_i is high and flags expired_o on the edge that
// would bring the count to TIMEOUT_CYCLES. The count restarts from zero
// whenever run_i is low, so each transaction gets a fresh budget.
//
// Ports:
//   clk        system clock
//   clear_i    synchronous active-low reset
//   run_i      high while a transaction is waiting for memory
//   expired_o  high on the cycle whose edge exhausts the budget
// -----------------------------------------------------------------------------
module mdr_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = run_i ? cnt_q + 1'b1 : '0;
    end

    // cnt_q counts completed wait edges, so the Nth edge sees N-1 here.
    assign expired_o = run_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!clear_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : mdr_timeout_ctr

// File: rtl/mdr_unit.sv
// -----------------------------------------------------------------------------
// mdr_unit -- memory data register with a single-outstanding memory handshake.
//
// In IDLE the unit accepts a read strobe, a write strobe or a bus load, in that
// priority order. A read waits for mem_ready and captures mem_rdata into the
// MDR; a write presents the MDR on mem_wdata until mem_ready. Completion gives
// a one-cycle done pulse.
//
// Build option:
//   MDR_TIMEOUT_EN  adds a watchdog (mdr_timeout_ctr); a transaction that sees
//                   no mem_ready within TIMEOUT_CYCLES wait cycles is abandoned
//                   with a one-cycle err pulse. Without it err is tied low.
//
// Ports:
//   clk        system clock, rising edge
//   clear      synchronous active-low reset
//   mdr_in     load mdr_q from bus_in (IDLE only)
//   bus_in     internal bus data
//   rd_start   strobe: read memory into the MDR
//   wr_start   strobe: write the MDR to memory
//   mem_rdata  memory read data, valid with mem_ready
//   mem_ready  memory completion acknowledge
//   mem_req    registered memory request
//   mem_we     registered write qualifier (1 = write)
//   mem_wdata  write data, equal to mdr_q
//   mdr_q      MDR contents
//   busy       high outside IDLE
//   done       one-cycle completion pulse
//   err        one-cycle watchdog abort pulse
// -----------------------------------------------------------------------------
module mdr_unit
    import mdr_pkg::*;
#(
    parameter int DATA_W         = MDR_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              mdr_in,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              rd_start,
    input  logic              wr_start,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mdr_q,
    output logic              busy,
    output logic              done,
    output logic              err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mdr_unit: TIMEOUT_CYCLES must be at least 1");
    end

    mdr_state_e        state_q, state_d;
    logic [DATA_W-1:0] mdr_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              timeout_hit;

    assign busy      = (state_q != IDLE);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mdr_q;
    assign done      = done_q;
    assign err       = err_q;

`ifdef MDR_TIMEOUT_EN
    mdr_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .clear_i   (clear),
        .run_i     (busy),
        .expired_o (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: every output of this block is given a default before the case so
    // no path leaves a variable unassigned, which would infer a latch.
    always_comb begin
        state_d   = state_q;
        mdr_d     = mdr_q;
        mem_req_d = mem_req_q;
        mem_we_d  = mem_we_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // mem_ready is deliberately not looked at here.
                if (rd_start) begin
                    state_d   = RD_WAIT;
                    mem_req_d = 1'b1;
                    mem_we_d  = 1'b0;
                end else if (wr_start) begin
                    state_d   = WR_WAIT;
                    mem_req_d = 1'b1;
                    mem_we_d  = 1'b1;
                end else if (mdr_in) begin
                    mdr_d = bus_in;
                end
            end

            RD_WAIT: begin
                // mem_ready wins over a simultaneous watchdog expiry.
                if (mem_ready) begin
                    state_d   = IDLE;
                    mdr_d     = mem_rdata;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    done_d    = 1'b1;
                end else if (timeout_hit) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    err_d     = 1'b1;
                end
            end

            WR_WAIT: begin
                if (mem_ready) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    done_d    = 1'b1;
                end else if (timeout_hit) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    err_d     = 1'b1;
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!clear) begin
            state_q   <= IDLE;
            mdr_q     <= '0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mdr_q     <= mdr_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

endmodule : mdr_unit

// File: tb/tb_mdr_unit.sv
// -----------------------------------------------------------------------------
// tb_mdr_unit -- self-checking bench for mdr_unit.
//
// Directed stimulus pushes the expected completion (done or err, plus the MDR
// value) into a queue; a monitor pops and compares whenever the DUT pulses
// done or err. Level checks on mem_req/mem_we/busy/mdr_q are made #1 after
// the clock edge. Watchdog cases run only when MDR_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_mdr_unit;
    import mdr_pkg::*;

    localparam int DW = 32;
    localparam int TO = 16;

    typedef struct {
        logic          is_err;
        logic [DW-1:0] mdr;
    } exp_t;

    logic          clk = 1'b0;
    logic          clear;
    logic          mdr_in;
    logic [DW-1:0] bus_in;
    logic          rd_start;
    logic          wr_start;
    logic [DW-1:0] mdr_q;
    logic          busy;
    logic          done;
    logic          err;

    mdr_if #(.DATA_W(DW)) mem_bus ();

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    mdr_unit #(
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .clear     (clear),
        .mdr_in    (mdr_in),
        .bus_in    (bus_in),
        .rd_start  (rd_start),
        .wr_start  (wr_start),
        .mem_rdata (mem_bus.mem_rdata),
        .mem_ready (mem_bus.mem_ready),
        .mem_req   (mem_bus.mem_req),
        .mem_we    (mem_bus.mem_we),
        .mem_wdata (mem_bus.mem_wdata),
        .mdr_q     (mdr_q),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_txn(input logic is_err, input logic [DW-1:0] mdr);
        exp_t e;
        e.is_err = is_err;
        e.mdr    = mdr;
        sb_q.push_back(e);
    endtask

    // Monitor: every done/err pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (done || err) begin
            if (sb_q.size() == 0) begin
                check("unexpected_completion", {30'd0, done, err}, '0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("completion_kind", {30'd0, done, err},
                      e.is_err ? 32'd1 : 32'd2);
                check("completion_mdr", mdr_q, e.mdr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "bench timed out");
    end

    initial begin
        clear             = 1'b0;
        mdr_in            = 1'b0;
        bus_in            = '0;
        rd_start          = 1'b0;
        wr_start          = 1'b0;
        mem_bus.mem_rdata = '0;
        mem_bus.mem_ready = 1'b0;

        // Reset, with every other input asserted to show reset dominates.
        rd_start = 1'b1; wr_start = 1'b1; mdr_in = 1'b1; bus_in = 32'hFFFF_0000;
        step();
        step();
        check("rst_mdr_q", mdr_q, '0);
        check("rst_mem_req", mem_bus.mem_req, '0);
        check("rst_mem_we", mem_bus.mem_we, '0);
        check("rst_busy", busy, '0);
        check("rst_done", done, '0);
        check("rst_err", err, '0);
        rd_start = 1'b0; wr_start = 1'b0; mdr_in = 1'b0;
        clear = 1'b1;
        step();

        // Bus load.
        mdr_in = 1'b1; bus_in = 32'hA5A5_A5A5;
        step();
        mdr_in = 1'b0;
        check("load_mdr_q", mdr_q, 32'hA5A5_A5A5);
        check("load_busy", busy, '0);

        // mem_ready in IDLE is ignored.
        mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'hFFFF_FFFF;
        step();
        mem_bus.mem_ready = 1'b0;
        check("idle_ready_mdr_q", mdr_q, 32'hA5A5_A5A5);
        check("idle_ready_busy", busy, '0);

        // Read with acknowledge three cycles after the strobe edge;
        // strobes issued while busy must be ignored.
        rd_start = 1'b1;
        expect_txn(1'b0, 32'hDEAD_BEEF);
        step();
        rd_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rd_mem_req", mem_bus.mem_req, 1'b1);
            check("rd_mem_we", mem_bus.mem_we, 1'b0);
            check("rd_busy", busy, 1'b1);
            check("rd_mdr_hold", mdr_q, 32'hA5A5_A5A5);
            wr_start = (i == 1);
            mdr_in   = (i == 1);
            bus_in   = 32'h1111_1111;
            if (i == 2) begin
                mem_bus.mem_ready = 1'b1;
                mem_bus.mem_rdata = 32'hDEAD_BEEF;
            end
            step();
        end
        mem_bus.mem_ready = 1'b0;
        check("rd_end_mdr_q", mdr_q, 32'hDEAD_BEEF);
        check("rd_end_mem_req", mem_bus.mem_req, '0);
        check("rd_end_busy", busy, '0);

        // Priority: read beats write and load.
        mdr_in = 1'b1; bus_in = 32'h1234_5678;
        step();
        check("pri_load", mdr_q, 32'h1234_5678);
        rd_start = 1'b1; wr_start = 1'b1; mdr_in = 1'b1; bus_in = 32'hCAFE_F00D;
        expect_txn(1'b0, 32'h1234_5678);
        step();
        rd_start = 1'b0; wr_start = 1'b0; mdr_in = 1'b0;
        check("pri_mem_req", mem_bus.mem_req, 1'b1);
        check("pri_mem_we", mem_bus.mem_we, 1'b0);
        check("pri_no_load", mdr_q, 32'h1234_5678);
        mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'h1234_5678;
        step();
        mem_bus.mem_ready = 1'b0;

        // Write: wdata held until acknowledge; read data must not load.
        wr_start = 1'b1;
        expect_txn(1'b0, 32'h1234_5678);
        step();
        wr_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("wr_mem_req", mem_bus.mem_req, 1'b1);
            check("wr_mem_we", mem_bus.mem_we, 1'b1);
            check("wr_wdata", mem_bus.mem_wdata, 32'h1234_5678);
            if (i == 1) begin
                mem_bus.mem_ready = 1'b1;
                mem_bus.mem_rdata = 32'h0BAD_0BAD;
            end
            step();
        end
        mem_bus.mem_ready = 1'b0;
        check("wr_end_mdr_q", mdr_q, 32'h1234_5678);
        check("wr_end_mem_we", mem_bus.mem_we, '0);

        // Back-to-back minimum-length read in the cycle after done.
        rd_start = 1'b1;
        expect_txn(1'b0, 32'h0F0F_0F0F);
        step();
        rd_start = 1'b0;
        check("b2b_busy", busy, 1'b1);
        mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'h0F0F_0F0F;
        step();
        mem_bus.mem_ready = 1'b0;
        check("b2b_mdr_q", mdr_q, 32'h0F0F_0F0F);
        check("b2b_busy_end", busy, '0);

        // Reset two cycles into a read abandons it with no done or err.
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        step();
        clear = 1'b0;
        mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'h7777_7777;
        step();
        clear = 1'b1;
        mem_bus.mem_ready = 1'b0;
        check("rstmid_mdr_q", mdr_q, '0);
        check("rstmid_mem_req", mem_bus.mem_req, '0);
        check("rstmid_busy", busy, '0);
        step();
        check("rstmid_idle_after", mem_bus.mem_req, '0);

`ifdef MDR_TIMEOUT_EN
        // No acknowledge: err on the 16th wait edge, mdr_q unchanged.
        mdr_in = 1'b1; bus_in = 32'h3C3C_3C3C;
        step();
        mdr_in = 1'b0;
        rd_start = 1'b1;
        expect_txn(1'b1, 32'h3C3C_3C3C);
        step();
        rd_start = 1'b0;
        repeat (TO - 1) step();
        check("to_busy_before", busy, 1'b1);
        step();
        check("to_busy_after", busy, '0);
        check("to_mem_req_after", mem_bus.mem_req, '0);

        // Acknowledge on the 16th wait edge completes normally.
        rd_start = 1'b1;
        expect_txn(1'b0, 32'h55AA_55AA);
        step();
        rd_start = 1'b0;
        repeat (TO - 1) step();
        mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'h55AA_55AA;
        step();
        mem_bus.mem_ready = 1'b0;
        check("to_edge_mdr_q", mdr_q, 32'h55AA_55AA);
`else
        // Without the watchdog a long wait never aborts.
        rd_start = 1'b1;
        expect_txn(1'b0, 32'h55AA_55AA);
        step();
        rd_start = 1'b0;
        repeat (3 * TO) step();
        check("long_wait_busy", busy, 1'b1);
        check("long_wait_err", err, '0);
        mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'h55AA_55AA;
        step();
        mem_bus.mem_ready = 1'b0;
        check("long_wait_mdr_q", mdr_q, 32'h55AA_55AA);
`endif

        step();
        step();
        check("scoreboard_drained", sb_q.size(), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mdr_unit

// File: doc/mdr_unit.md
MDR_UNIT -- requirements
Module: mdr_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of the data path.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16: watchdog limit in cycles (used only with MDR_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port clear  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port mdr_in  input  1  load mdr_q from bus_in.
REQ-006 SHALL have port bus_in  input  DATA_W  data from internal bus.
REQ-007 SHALL have port rd_start  input  1  one-cycle strobe: begin memory read into MDR.
REQ-008 SHALL have port wr_start  input  1  one-cycle strobe: begin memory write of mdr_q.
REQ-009 SHALL have port mem_rdata  input  DATA_W  memory read data, valid with mem_ready.
REQ-010 SHALL have port mem_ready  input  1  memory completion acknowledge.
REQ-011 SHALL have port mem_req  output  1  registered memory request, held until acknowledged.
REQ-012 SHALL have port mem_we  output  1  registered write qualifier: 1 = write, 0 = read.
REQ-013 SHALL have port mem_wdata  output  DATA_W  write data; equals mdr_q.
REQ-014 SHALL have port mdr_q  output  DATA_W  MDR contents, feeding the bus and the downstream 32-bit registers.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse on transaction completion.
REQ-017 SHALL have port err  output  1  one-cycle pulse on watchdog abort.

Function
REQ-018 SHALL implement the states IDLE, RD_WAIT and WR_WAIT.
REQ-019 In IDLE, SHALL apply priority rd_start > wr_start > mdr_in when these are asserted together.
REQ-020 In IDLE, rd_start SHALL move the block to RD_WAIT at the next edge with mem_req=1 and mem_we=0.
REQ-021 In IDLE, wr_start SHALL move the block to WR_WAIT at the next edge with mem_req=1 and mem_we=1.
REQ-022 In IDLE with mdr_in=1 and no start strobe, SHALL load mdr_q <= bus_in at the next edge (1-cycle latency).
REQ-023 In RD_WAIT, an edge with mem_ready=1 SHALL load mdr_q <= mem_rdata, pulse done, clear mem_req and mem_we, and return to IDLE.
REQ-024 In WR_WAIT, SHALL hold mdr_q and mem_wdata stable, and an edge with mem_ready=1 SHALL pulse done, clear mem_req and mem_we, and return to IDLE.
REQ-025 SHALL ignore rd_start, wr_start and mdr_in while busy=1.
REQ-026 SHALL ignore mem_ready in IDLE, with no change to outputs.
REQ-027 SHALL give a minimum transaction of 2 cycles (strobe edge, then acknowledge edge); a new strobe SHALL be accepted in the cycle after done.

Reset
REQ-028 On clear=0 at a rising edge, SHALL force state=IDLE, mdr_q=0, mem_req=0, mem_we=0, busy=0, done=0, err=0, and watchdog count=0.
REQ-029 Reset during RD_WAIT or WR_WAIT SHALL abandon the transaction: mem_req=0 from the next cycle, with no done or err pulse.
REQ-030 Reset SHALL override every simultaneous input.

Configuration
REQ-031 With MDR_TIMEOUT_EN defined, SHALL count cycles spent in RD_WAIT/WR_WAIT; when the count reaches TIMEOUT_CYCLES without mem_ready, SHALL pulse err, return to IDLE, leave mdr_q unchanged, and not pulse done.
REQ-032 If mem_ready arrives on the same edge the count reaches TIMEOUT_CYCLES, SHALL complete normally with done and no err.
REQ-033 Without MDR_TIMEOUT_EN, SHALL wait indefinitely for mem_ready, tie err to 0, and include no counter logic.

Structure
REQ-034 Package mdr_pkg SHALL hold the state enum (IDLE, RD_WAIT, WR_WAIT) and the DATA_W default constant.
REQ-035 Watchdog SHALL be sub-module mdr_timeout_ctr, instantiated only under MDR_TIMEOUT_EN.

Verification
REQ-036 Load test: mdr_in=1, bus_in=32'hA5A5A5A5 in IDLE -> mdr_q=32'hA5A5A5A5 one edge later, busy stays 0.
REQ-037 Read test: rd_start, mem_ready asserted 3 cycles later with mem_rdata=32'hDEADBEEF -> mem_req=1 and mem_we=0 for 3 cycles, then mdr_q=32'hDEADBEEF and one done pulse.
REQ-038 Write/priority test: mdr_q=32'h12345678, then rd_start, wr_start and mdr_in asserted together -> read taken (mem_we=0); repeat with wr_start alone -> mem_wdata=32'h12345678 held until mem_ready, then done.
REQ-039 Reset mid-read: clear=0 two cycles into RD_WAIT -> mdr_q=0, mem_req=0, no done or err.
REQ-040 Timeout (MDR_TIMEOUT_EN, TIMEOUT_CYCLES=16): rd_start with no mem_ready -> err pulse after 16 cycles, mdr_q unchanged; separately, mem_ready on cycle 16 -> done and no err.
